mario_anim_ctrl: RTL and testbench
==================================

Name: mario_anim_ctrl

Overview:
- Sequences Mario's sprite animation and the question-block tile animation for the color mapper.
- Replaces the free-running frame counters and the ad-hoc look-direction latch with one synchronous controller.
- Runs on the 50 MHz clock and samples frame_clk as a data input.
- Outputs drive the sprite ROM address select (ani_index, look_dir) and the question-block tile substitution (q_tile).

Parameters:
- WALK_DIV, 5, frames per walk-cycle step (index 1→2→3→1).
- JUMP_FRAMES, 24, frames a jump lasts before returning to STAND.
- Q_DIV, 21, frames per question-block phase.
- CNT_W, 6, width of the internal frame counters; must hold max(WALK_DIV, JUMP_FRAMES, Q_DIV)-1.

Ports:
- Clk  in  1  50 MHz system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  vertical-sync-rate strobe; asynchronous to Clk; sampled only.
- keycode  in  8  current USB keycode; 0x07 right, 0x04 left, 0x26 jump, anything else means none.
- ani_index  out  3  sprite frame: 0 stand, 1-3 walk, 4 jump.
- look_dir  out  1  1 = facing right, 0 = facing left (mapper mirrors X when 0).
- jumping  out  1  high while in JUMP.
- q_tile  out  5  tile index substituted for tile 6: 6, 8 or 10.
- frame_tick  out  1  one-Clk pulse per frame_clk rising edge (debug/reuse).

Behaviour:
- One clock: Clk. Reset is synchronous and active-high. Every register updates only on the Clk rising edge.
- Reset values:
  - state=STAND, ani_index=0, look_dir=1, jumping=0, q_tile=6, frame_tick=0.
  - Internal: walk_cnt=0, jump_cnt=0, q_cnt=0, q_phase=0, synchronizer flops=0.
- Tick generation:
  - frame_clk passes through a 2-flop synchronizer, then a third flop for edge detect.
  - frame_tick = sync2 & ~sync3.
  - frame_tick is high for exactly one Clk cycle, 3 Clk cycles after frame_clk rises (±1 for metastability).
  - A frame_clk held high produces one tick only.
- All FSM and counter updates occur only on cycles where frame_tick=1. Outputs are registered, so each change is visible on the Clk edge ending the tick cycle.
- keycode is sampled on the tick cycle only.
- FSM transitions:
  - STAND:
    - 0x26 → JUMP; jump_cnt=0, ani_index=4, jumping=1.
    - 0x07 → WALK; look_dir=1, ani_index=1, walk_cnt=0.
    - 0x04 → WALK; look_dir=0, ani_index=1, walk_cnt=0.
    - Else stay in STAND, ani_index=0.
  - WALK:
    - 0x26 → JUMP, same actions as from STAND.
    - Key matches look_dir:
      - If walk_cnt==WALK_DIV-1: walk_cnt=0 and ani_index advances 1→2→3→1.
      - Else walk_cnt+1.
    - Key opposite to look_dir: look_dir toggles, ani_index=1, walk_cnt=0.
    - No key → STAND, ani_index=0, walk_cnt=0.
  - JUMP:
    - Jump cannot be cancelled. 0x07 and 0x04 still update look_dir; ani_index stays 4.
    - If jump_cnt==JUMP_FRAMES-1: → STAND, ani_index=0, jumping=0, jump_cnt=0.
    - Else jump_cnt+1.
    - Holding 0x26 at jump end yields one tick in STAND, then a new jump on the following tick.
- Question block:
  - On each tick q_cnt increments.
  - At Q_DIV-1, q_cnt wraps to 0 and q_phase advances 0→1→2→0.
  - q_tile = 6 + 2*q_phase.
  - Independent of the Mario FSM.
- Simultaneous events: Reset has priority over frame_tick on the same cycle; a reset mid-jump returns to STAND with look_dir=1 on the next edge.
- Counters never exceed their terminal value. No state is reachable outside STAND/WALK/JUMP; the default branch returns to STAND.

Decomposition:
- mario_pkg:
  - anim_state_t enum {STAND, WALK, JUMP}.
  - KEY_RIGHT=8'h07, KEY_LEFT=8'h04, KEY_JUMP=8'h26.
  - ANI_STAND=0, ANI_WALK0=1, ANI_JUMP=4, Q_TILE_BASE=6.
- Sub-module frame_tick_sync: 3-flop synchronizer and edge detector. Ports: Clk, Reset, frame_clk → frame_tick.

Test Plan:
1. Reset, then 5 frame_clk pulses with keycode=0 → ani_index=0, look_dir=1, jumping=0, q_tile=6 throughout.
2. keycode=0x07 held for 16 ticks → ani_index=1 after tick 1, 2 after tick 6, 3 after tick 11, 1 after tick 16; look_dir=1.
3. Walking right, switch to 0x04 → on the next tick look_dir=0, ani_index=1, and walk_cnt restarts (next advance 5 ticks later).
4. keycode=0x26 for one tick, then 0x04 → ani_index=4 and jumping=1 for 24 ticks, look_dir=0 after the first left tick; ani_index=0 on tick 25.
5. 63 ticks, any keys → q_tile becomes 8 after tick 21, 10 after tick 42, 6 after tick 63.
6. Assert Reset on a frame_tick cycle at jump_cnt=10 → next edge: ani_index=0, jumping=0, look_dir=1, q_tile=6. frame_clk held high for 100 Clk → exactly one frame_tick.

Source files
------------

// File: rtl/mario_pkg.sv
// Shared constants and types for the Mario sprite / question-block animation controller.
package mario_pkg;

  typedef enum logic [1:0] {
    STAND = 2'd0,
    WALK  = 2'd1,
    JUMP  = 2'd2
  } anim_state_t;

  localparam logic [7:0] KEY_RIGHT   = 8'h07;
  localparam logic [7:0] KEY_LEFT    = 8'h04;
  localparam logic [7:0] KEY_JUMP    = 8'h26;

  localparam logic [2:0] ANI_STAND   = 3'd0;
  localparam logic [2:0] ANI_WALK0   = 3'd1;
  localparam logic [2:0] ANI_JUMP    = 3'd4;

  localparam logic [4:0] Q_TILE_BASE = 5'd6;

endpackage

// File: rtl/mario_anim_ctrl_if.sv
// Keycode in, sprite/tile selects out, between the controller and the color mapper.
interface mario_anim_ctrl_if;
  logic [7:0] keycode;
  logic [2:0] ani_index;
  logic       look_dir;
  logic       jumping;
  logic [4:0] q_tile;
  logic       frame_tick;

  modport master (
    output keycode,
    input  ani_index, look_dir, jumping, q_tile, frame_tick
  );

  modport slave (
    input  keycode,
    output ani_index, look_dir, jumping, q_tile, frame_tick
  );
endinterface

// File: rtl/frame_tick_sync.sv
// Brings frame_clk into the Clk domain and emits a single-cycle pulse on its rising edge.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_tick
);

  logic sync1_q, sync2_q, sync3_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign frame_tick = sync2_q & ~sync3_q;

endmodule

// File: rtl/mario_anim_ctrl.sv
// Frame-rate animation sequencer: Mario stand/walk/jump frames, facing direction,
// and the free-running question-block tile phase.
module mario_anim_ctrl
  import mario_pkg::*;
#(
  parameter int WALK_DIV    = 5,
  parameter int JUMP_FRAMES = 24,
  parameter int Q_DIV       = 21,
  parameter int CNT_W       = 6
) (
  input logic              Clk,
  input logic              Reset,
  input logic              frame_clk,
  mario_anim_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_DIV - 1);
  localparam logic [CNT_W-1:0] JUMP_LAST = CNT_W'(JUMP_FRAMES - 1);
  localparam logic [CNT_W-1:0] Q_LAST    = CNT_W'(Q_DIV - 1);

  logic             tick;
  anim_state_t      state_q, state_d;
  logic [2:0]       ani_q, ani_d;
  logic             look_dir_q, look_dir_d;
  logic [CNT_W-1:0] walk_cnt_q, walk_cnt_d;
  logic [CNT_W-1:0] jump_cnt_q, jump_cnt_d;
  logic [CNT_W-1:0] q_cnt_q, q_cnt_d;
  logic [1:0]       q_phase_q, q_phase_d;
  logic             key_right, key_left, key_jump, key_fwd, key_back;

  frame_tick_sync u_sync (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .frame_tick (tick)
  );

  assign key_right = (bus.keycode == KEY_RIGHT);
  assign key_left  = (bus.keycode == KEY_LEFT);
  assign key_jump  = (bus.keycode == KEY_JUMP);
  assign key_fwd   = look_dir_q ? key_right : key_left;
  assign key_back  = look_dir_q ? key_left  : key_right;

  always_comb begin
    state_d    = state_q;
    ani_d      = ani_q;
    look_dir_d = look_dir_q;
    walk_cnt_d = walk_cnt_q;
    jump_cnt_d = jump_cnt_q;
    q_cnt_d    = q_cnt_q;
    q_phase_d  = q_phase_q;

    if (tick) begin
      if (q_cnt_q == Q_LAST) begin
        q_cnt_d   = '0;
        q_phase_d = (q_phase_q == 2'd2) ? 2'd0 : q_phase_q + 2'd1;
      end else begin
        q_cnt_d = q_cnt_q + 1'b1;
      end

      case (state_q)
        STAND: begin
          if (key_jump) begin
            state_d    = JUMP;
            jump_cnt_d = '0;
            ani_d      = ANI_JUMP;
          end else if (key_right || key_left) begin
            state_d    = WALK;
            look_dir_d = key_right;
            ani_d      = ANI_WALK0;
            walk_cnt_d = '0;
          end else begin
            ani_d = ANI_STAND;
          end
        end
        WALK: begin
          if (key_jump) begin
            state_d    = JUMP;
            jump_cnt_d = '0;
            ani_d      = ANI_JUMP;
          end else if (key_fwd) begin
            if (walk_cnt_q == WALK_LAST) begin
              walk_cnt_d = '0;
              ani_d      = (ani_q == 3'd3) ? ANI_WALK0 : ani_q + 3'd1;
            end else begin
              walk_cnt_d = walk_cnt_q + 1'b1;
            end
          end else if (key_back) begin
            look_dir_d = ~look_dir_q;
            ani_d      = ANI_WALK0;
            walk_cnt_d = '0;
          end else begin
            state_d    = STAND;
            ani_d      = ANI_STAND;
            walk_cnt_d = '0;
          end
        end
        JUMP: begin
          // Direction keys steer the facing mid-air but never cut the jump short.
          if (key_right || key_left) look_dir_d = key_right;
          if (jump_cnt_q == JUMP_LAST) begin
            state_d    = STAND;
            ani_d      = ANI_STAND;
            jump_cnt_d = '0;
          end else begin
            jump_cnt_d = jump_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = STAND;
          ani_d   = ANI_STAND;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= STAND;
      ani_q      <= ANI_STAND;
      look_dir_q <= 1'b1;
      walk_cnt_q <= '0;
      jump_cnt_q <= '0;
      q_cnt_q    <= '0;
      q_phase_q  <= 2'd0;
    end else begin
      state_q    <= state_d;
      ani_q      <= ani_d;
      look_dir_q <= look_dir_d;
      walk_cnt_q <= walk_cnt_d;
      jump_cnt_q <= jump_cnt_d;
      q_cnt_q    <= q_cnt_d;
      q_phase_q  <= q_phase_d;
    end
  end

  assign bus.ani_index  = ani_q;
  assign bus.look_dir   = look_dir_q;
  assign bus.jumping    = (state_q == JUMP);
  assign bus.q_tile     = Q_TILE_BASE + {2'b00, q_phase_q, 1'b0};
  assign bus.frame_tick = tick;

endmodule

// File: tb/tb_mario_anim_ctrl.sv
// Directed bench for mario_anim_ctrl: walk cycle, turns, jump timing, question-block
// phases, reset mid-jump and single-tick behaviour of a held frame_clk.
module tb_mario_anim_ctrl;
  import mario_pkg::*;

  logic Clk;
  logic Reset;
  logic frame_clk;
  int   checks;
  int   errors;
  int   tick_count;

  mario_anim_ctrl_if bus ();

  mario_anim_ctrl dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .bus       (bus)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  always @(negedge Clk) if (bus.frame_tick === 1'b1) tick_count++;

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_mario(input string tag, input logic [2:0] ani, input logic look,
                             input logic jmp);
    check({tag, "_ani"},  {5'd0, bus.ani_index}, {5'd0, ani});
    check({tag, "_look"}, {7'd0, bus.look_dir},  {7'd0, look});
    check({tag, "_jump"}, {7'd0, bus.jumping},   {7'd0, jmp});
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
  endtask

  // Raises frame_clk, waits for the tick, and returns #1 after the edge that ends the tick cycle.
  task automatic do_tick(input logic [7:0] key, input bit rst_on_tick);
    int waited;
    bus.keycode = key;
    frame_clk   = 1'b1;
    waited      = 0;
    while (bus.frame_tick !== 1'b1 && waited < 10) begin
      @(posedge Clk);
      #1;
      waited++;
    end
    check("tick_seen", {7'd0, bus.frame_tick}, 8'd1);
    if (rst_on_tick) begin
      Reset     = 1'b1;
      frame_clk = 1'b0;
    end
    @(posedge Clk);
    #1;
    if (!rst_on_tick) begin
      frame_clk = 1'b0;
      repeat (4) @(posedge Clk);
      #1;
    end
  endtask

  initial begin
    logic [2:0] exp_ani;
    logic [4:0] exp_q;
    checks      = 0;
    errors      = 0;
    tick_count  = 0;
    Reset       = 1'b1;
    frame_clk   = 1'b0;
    bus.keycode = 8'h00;
    repeat (3) @(posedge Clk);
    #1;
    check_mario("reset", 3'd0, 1'b1, 1'b0);
    check("reset_q", {3'd0, bus.q_tile}, 8'd6);
    check("reset_tick", {7'd0, bus.frame_tick}, 8'd0);
    Reset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;

    $display("[TB] idle frames");
    for (int i = 0; i < 5; i++) begin
      do_tick(8'h00, 1'b0);
      check_mario("idle", 3'd0, 1'b1, 1'b0);
      check("idle_q", {3'd0, bus.q_tile}, 8'd6);
    end

    $display("[TB] walk right");
    for (int i = 1; i <= 16; i++) begin
      do_tick(KEY_RIGHT, 1'b0);
      if (i < 6) exp_ani = 3'd1;
      else if (i < 11) exp_ani = 3'd2;
      else if (i < 16) exp_ani = 3'd3;
      else exp_ani = 3'd1;
      check_mario("walk_r", exp_ani, 1'b1, 1'b0);
    end

    $display("[TB] turn left");
    do_tick(KEY_LEFT, 1'b0);
    check_mario("turn", 3'd1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do_tick(KEY_LEFT, 1'b0);
      check_mario("walk_l", 3'd1, 1'b0, 1'b0);
    end
    do_tick(KEY_LEFT, 1'b0);
    check_mario("walk_l_adv", 3'd2, 1'b0, 1'b0);
    do_tick(8'h00, 1'b0);
    check_mario("walk_stop", 3'd0, 1'b0, 1'b0);

    $display("[TB] jump");
    do_tick(KEY_RIGHT, 1'b0);
    check_mario("pre_jump", 3'd1, 1'b1, 1'b0);
    do_tick(KEY_JUMP, 1'b0);
    check_mario("jump_start", 3'd4, 1'b1, 1'b1);
    for (int i = 2; i <= 24; i++) begin
      do_tick(KEY_LEFT, 1'b0);
      check_mario("jump_air", 3'd4, 1'b0, 1'b1);
    end
    do_tick(KEY_LEFT, 1'b0);
    check_mario("jump_land", 3'd0, 1'b0, 1'b0);

    $display("[TB] held jump key");
    do_tick(KEY_JUMP, 1'b0);
    for (int i = 2; i <= 24; i++) do_tick(KEY_JUMP, 1'b0);
    check_mario("hold_air", 3'd4, 1'b0, 1'b1);
    do_tick(KEY_JUMP, 1'b0);
    check_mario("hold_land", 3'd0, 1'b0, 1'b0);
    do_tick(KEY_JUMP, 1'b0);
    check_mario("hold_rejump", 3'd4, 1'b0, 1'b1);

    $display("[TB] question block");
    do_reset();
    for (int i = 1; i <= 63; i++) begin
      do_tick((i % 3 == 0) ? KEY_RIGHT : 8'h00, 1'b0);
      if (i < 21) exp_q = 5'd6;
      else if (i < 42) exp_q = 5'd8;
      else if (i < 63) exp_q = 5'd10;
      else exp_q = 5'd6;
      check("q_tile", {3'd0, bus.q_tile}, {3'd0, exp_q});
    end

    $display("[TB] reset mid-jump");
    do_reset();
    do_tick(KEY_JUMP, 1'b0);
    for (int i = 0; i < 10; i++) do_tick(KEY_LEFT, 1'b0);
    check_mario("mid_jump", 3'd4, 1'b0, 1'b1);
    do_tick(KEY_LEFT, 1'b1);
    check_mario("rst_jump", 3'd0, 1'b1, 1'b0);
    check("rst_jump_q", {3'd0, bus.q_tile}, 8'd6);
    Reset = 1'b0;
    bus.keycode = 8'h00;
    repeat (4) @(posedge Clk);
    #1;

    $display("[TB] held frame_clk");
    tick_count = 0;
    frame_clk  = 1'b1;
    repeat (100) @(posedge Clk);
    #1;
    check("held_ticks", tick_count[7:0], 8'd1);
    frame_clk = 1'b0;
    repeat (4) @(posedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
